// File: rtl/mem_nack_queue_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mem_nack_queue_if                                                |
// | Purpose : Core-side and memory-side request/response bundle                |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface mem_nack_queue_if #(
    parameter int ADDR_BITS = 26,
    parameter int DATA_BITS = 128,
    parameter int TAG_BITS  = 4
);
    logic                 up_req_val;
    logic                 up_req_rdy;
    logic                 up_req_rw;
    logic [ADDR_BITS-1:0] up_req_addr;
    logic [DATA_BITS-1:0] up_req_data;
    logic [TAG_BITS-1:0]  up_req_tag;

    logic                 up_resp_val;
    logic                 up_resp_nack;
    logic [DATA_BITS-1:0] up_resp_data;
    logic [TAG_BITS-1:0]  up_resp_tag;

    logic                 dn_req_val;
    logic                 dn_req_rdy;
    logic                 dn_req_rw;
    logic [ADDR_BITS-1:0] dn_req_addr;
    logic [DATA_BITS-1:0] dn_req_data;
    logic [TAG_BITS-1:0]  dn_req_tag;

    logic                 dn_resp_val;
    logic [DATA_BITS-1:0] dn_resp_data;
    logic [TAG_BITS-1:0]  dn_resp_tag;

    modport slave (
        input  up_req_val, up_req_rw, up_req_addr, up_req_data, up_req_tag,
        input  dn_req_rdy, dn_resp_val, dn_resp_data, dn_resp_tag,
        output up_req_rdy, up_resp_val, up_resp_nack, up_resp_data, up_resp_tag,
        output dn_req_val, dn_req_rw, dn_req_addr, dn_req_data, dn_req_tag
    );

    modport master (
        output up_req_val, up_req_rw, up_req_addr, up_req_data, up_req_tag,
        output dn_req_rdy, dn_resp_val, dn_resp_data, dn_resp_tag,
        input  up_req_rdy, up_resp_val, up_resp_nack, up_resp_data, up_resp_tag,
        input  dn_req_val, dn_req_rw, dn_req_addr, dn_req_data, dn_req_tag
    );
endinterface
`default_nettype wire

// File: rtl/mem_nack_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mem_nack_queue                                                   |
// | Purpose : Request FIFO toward memory; overflowing requests are nacked back |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module mem_nack_queue #(
    parameter int ADDR_BITS  = 26,
    parameter int DATA_BITS  = 128,
    parameter int TAG_BITS   = 4,
    parameter int REQ_DEPTH  = 4,
    parameter int NACK_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    mem_nack_queue_if.slave            bus,
    output logic [$clog2(REQ_DEPTH):0] req_count
);

    localparam int c_RPTR_W  = $clog2(REQ_DEPTH);
    localparam int c_RCNT_W  = c_RPTR_W + 1;
    localparam int c_NPTR_W  = (NACK_DEPTH > 1) ? $clog2(NACK_DEPTH) : 1;
    localparam int c_NCNT_W  = $clog2(NACK_DEPTH) + 1;
    localparam int c_ENTRY_W = 1 + ADDR_BITS + DATA_BITS + TAG_BITS;

    localparam logic [c_RCNT_W-1:0] c_REQ_FULL  = c_RCNT_W'(REQ_DEPTH);
    localparam logic [c_NCNT_W-1:0] c_NACK_FULL = c_NCNT_W'(NACK_DEPTH);
    localparam logic [c_NPTR_W-1:0] c_NPTR_LAST = c_NPTR_W'(NACK_DEPTH - 1);

    logic [c_ENTRY_W-1:0] r_req_mem [REQ_DEPTH];
    logic [c_RPTR_W-1:0]  r_req_rd_ptr;
    logic [c_RPTR_W-1:0]  r_req_wr_ptr;
    logic [c_RCNT_W-1:0]  r_req_count;

    logic [TAG_BITS-1:0]  r_nack_mem [NACK_DEPTH];
    logic [c_NPTR_W-1:0]  r_nack_rd_ptr;
    logic [c_NPTR_W-1:0]  r_nack_wr_ptr;
    logic [c_NCNT_W-1:0]  r_nack_count;

    logic w_up_req_rdy;
    logic w_accept;
    logic w_req_full;
    logic w_req_push;
    logic w_req_pop;
    logic w_dn_req_val;
    logic w_nack_val;
    logic w_nack_push;
    logic w_nack_pop;

    // Ready is gated by reset so the core sees it low while held in reset.
    assign w_up_req_rdy = reset & (r_nack_count != c_NACK_FULL);
    assign w_accept     = bus.up_req_val & w_up_req_rdy;
    assign w_req_full   = (r_req_count == c_REQ_FULL);
    assign w_req_push   = w_accept & ~w_req_full;
    assign w_nack_push  = w_accept & w_req_full;
    assign w_dn_req_val = (r_req_count != '0);
    assign w_req_pop    = w_dn_req_val & bus.dn_req_rdy;
    assign w_nack_val   = (r_nack_count != '0);
    assign w_nack_pop   = w_nack_val & ~bus.dn_resp_val;

    assign bus.up_req_rdy = w_up_req_rdy;
    assign bus.dn_req_val = w_dn_req_val;
    assign req_count      = r_req_count;

    assign {bus.dn_req_rw, bus.dn_req_addr, bus.dn_req_data, bus.dn_req_tag} =
        w_dn_req_val ? r_req_mem[r_req_rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (w_req_push) begin
            r_req_mem[r_req_wr_ptr] <= {bus.up_req_rw, bus.up_req_addr,
                                        bus.up_req_data, bus.up_req_tag};
        end
        if (w_nack_push) begin
            r_nack_mem[r_nack_wr_ptr] <= bus.up_req_tag;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_req_rd_ptr  <= '0;
            r_req_wr_ptr  <= '0;
            r_req_count   <= '0;
            r_nack_rd_ptr <= '0;
            r_nack_wr_ptr <= '0;
            r_nack_count  <= '0;
        end else begin
            if (w_req_push) r_req_wr_ptr <= r_req_wr_ptr + 1'b1;
            if (w_req_pop)  r_req_rd_ptr <= r_req_rd_ptr + 1'b1;
            r_req_count <= r_req_count + c_RCNT_W'(w_req_push) - c_RCNT_W'(w_req_pop);

            // Explicit wrap keeps a single-entry nack FIFO correct.
            if (w_nack_push) begin
                r_nack_wr_ptr <= (r_nack_wr_ptr == c_NPTR_LAST) ? '0 : r_nack_wr_ptr + 1'b1;
            end
            if (w_nack_pop) begin
                r_nack_rd_ptr <= (r_nack_rd_ptr == c_NPTR_LAST) ? '0 : r_nack_rd_ptr + 1'b1;
            end
            r_nack_count <= r_nack_count + c_NCNT_W'(w_nack_push) - c_NCNT_W'(w_nack_pop);
        end
    end

    // Memory responses always win; nacks only fill idle response slots.
    always_comb begin
        bus.up_resp_val  = 1'b0;
        bus.up_resp_nack = 1'b0;
        bus.up_resp_data = '0;
        bus.up_resp_tag  = '0;
        if (reset) begin
            if (bus.dn_resp_val) begin
                bus.up_resp_val  = 1'b1;
                bus.up_resp_data = bus.dn_resp_data;
                bus.up_resp_tag  = bus.dn_resp_tag;
            end else if (w_nack_val) begin
                bus.up_resp_nack = 1'b1;
                bus.up_resp_tag  = r_nack_mem[r_nack_rd_ptr];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_nack_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_mem_nack_queue                                                |
// | Purpose : Scoreboard bench for mem_nack_queue request and nack paths       |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_mem_nack_queue;

    localparam int c_AB = 26;
    localparam int c_DB = 128;
    localparam int c_TB = 4;
    localparam int c_RD = 4;
    localparam int c_ND = 2;

    typedef struct packed {
        logic            rw;
        logic [c_AB-1:0] addr;
        logic [c_DB-1:0] data;
        logic [c_TB-1:0] tag;
    } req_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] req_count;

    req_t            q_req[$];
    logic [c_TB-1:0] q_nack[$];

    int n_checks = 0;
    int n_pass = 0;
    int delivered = 0;
    int nacks_seen = 0;
    int cyc = 0;
    int peak = 0;
    int nack_cyc [16];
    int d0;
    int n0;

    always #5 clk = ~clk;

    mem_nack_queue_if #(.ADDR_BITS(c_AB), .DATA_BITS(c_DB), .TAG_BITS(c_TB)) bus ();

    mem_nack_queue #(
        .ADDR_BITS (c_AB),
        .DATA_BITS (c_DB),
        .TAG_BITS  (c_TB),
        .REQ_DEPTH (c_RD),
        .NACK_DEPTH(c_ND)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .req_count(req_count)
    );

    task automatic check_eq(input string name, input logic [191:0] got, input logic [191:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic rw, input logic [c_TB-1:0] tag);
        bit ok;
        ok = 1'b0;
        bus.up_req_val  = 1'b1;
        bus.up_req_rw   = rw;
        bus.up_req_addr = c_AB'($urandom);
        bus.up_req_data = {$urandom, $urandom, $urandom, $urandom};
        bus.up_req_tag  = tag;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.up_req_rdy;
            @(posedge clk);
            #1;
        end
        bus.up_req_val = 1'b0;
        if (!ok) check_eq("send_timeout", 0, 1);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: checks this cycle's outputs against start-of-cycle queues,
    // then applies the pops and pushes that the coming edge will perform.
    always @(negedge clk) begin : b_mon
        int              sz;
        bit              rdy_m;
        req_t            e;
        logic [c_TB-1:0] t;
        if (!reset) begin
            check_eq("reset_dn_side", {bus.up_req_rdy, bus.dn_req_val, bus.dn_req_rw, bus.dn_req_addr,
                                       bus.dn_req_data, bus.dn_req_tag, req_count}, '0);
            check_eq("reset_up_side", {bus.up_resp_val, bus.up_resp_nack, bus.up_resp_data,
                                       bus.up_resp_tag}, '0);
            q_req.delete();
            q_nack.delete();
        end else begin
            sz    = q_req.size();
            rdy_m = (q_nack.size() != c_ND);
            check_eq("up_req_rdy", bus.up_req_rdy, rdy_m);
            check_eq("req_count", req_count, sz);
            check_eq("dn_req_val", bus.dn_req_val, sz != 0);
            if (int'(req_count) > peak) peak = int'(req_count);
            if (sz != 0 && bus.dn_req_rdy) begin
                e = q_req.pop_front();
                check_eq("dn_req_fields", {bus.dn_req_rw, bus.dn_req_addr, bus.dn_req_data,
                                           bus.dn_req_tag}, e);
                delivered++;
            end
            if (bus.dn_resp_val) begin
                check_eq("resp_pass", {bus.up_resp_val, bus.up_resp_nack, bus.up_resp_data, bus.up_resp_tag},
                         {1'b1, 1'b0, bus.dn_resp_data, bus.dn_resp_tag});
            end else if (q_nack.size() != 0) begin
                t = q_nack.pop_front();
                check_eq("nack_resp", {bus.up_resp_val, bus.up_resp_nack, bus.up_resp_data, bus.up_resp_tag},
                         {1'b0, 1'b1, {c_DB{1'b0}}, t});
                nacks_seen++;
                nack_cyc[t] = cyc;
            end else begin
                check_eq("resp_idle", {bus.up_resp_val, bus.up_resp_nack, bus.up_resp_data,
                                       bus.up_resp_tag}, '0);
            end
            if (bus.up_req_val && rdy_m) begin
                if (sz < c_RD) begin
                    e = {bus.up_req_rw, bus.up_req_addr, bus.up_req_data, bus.up_req_tag};
                    q_req.push_back(e);
                end else begin
                    q_nack.push_back(bus.up_req_tag);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.up_req_val   = 1'b0;
        bus.up_req_rw    = 1'b0;
        bus.up_req_addr  = '0;
        bus.up_req_data  = '0;
        bus.up_req_tag   = '0;
        bus.dn_req_rdy   = 1'b0;
        bus.dn_resp_val  = 1'b0;
        bus.dn_resp_data = '0;
        bus.dn_resp_tag  = '0;

        #1;
        check_eq("rst_rdy", bus.up_req_rdy, 0);
        check_eq("rst_count", req_count, 0);
        check_eq("rst_dn_val", bus.dn_req_val, 0);
        tick(3);
        reset = 1'b1;
        @(negedge clk);
        check_eq("rdy_after_reset", bus.up_req_rdy, 1);
        tick(1);

        // Basic flow: three reads streamed straight through.
        bus.dn_req_rdy = 1'b1;
        peak = 0;
        d0 = delivered;
        send(1'b0, 4'd1);
        send(1'b0, 4'd2);
        send(1'b0, 4'd3);
        tick(4);
        check_eq("basic_delivered", delivered - d0, 3);
        check_eq("basic_peak", peak, 1);

        // Overflow with responses holding the nacks back.
        bus.dn_req_rdy   = 1'b0;
        bus.dn_resp_val  = 1'b1;
        bus.dn_resp_tag  = 4'd9;
        bus.dn_resp_data = {$urandom, $urandom, $urandom, $urandom};
        n0 = nacks_seen;
        for (int i = 0; i < 6; i++) send(1'b0, c_TB'(i));
        @(negedge clk);
        check_eq("ovf_rdy_low", bus.up_req_rdy, 0);
        check_eq("ovf_count", req_count, 4);
        tick(3);
        check_eq("ovf_rdy_held", bus.up_req_rdy, 0);
        bus.dn_resp_val = 1'b0;
        tick(4);
        check_eq("ovf_nacks", nacks_seen - n0, 2);
        check_eq("ovf_nack_spacing", nack_cyc[5] - nack_cyc[4], 1);

        // Nack for tag 7 waits out three response cycles.
        bus.dn_resp_val = 1'b1;
        bus.dn_resp_tag = 4'd9;
        send(1'b1, 4'd7);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("resp9", {bus.up_resp_val, bus.up_resp_nack, bus.up_resp_tag}, {1'b1, 1'b0, 4'd9});
        end
        @(posedge clk);
        #1;
        bus.dn_resp_val = 1'b0;
        @(negedge clk);
        check_eq("nack7", {bus.up_resp_nack, bus.up_resp_tag}, {1'b1, 4'd7});
        tick(1);

        // Full FIFO with a dequeue in the same cycle still nacks.
        bus.dn_req_rdy = 1'b1;
        send(1'b0, 4'd8);
        bus.dn_req_rdy = 1'b0;
        check_eq("full_deq_count", req_count, 3);
        @(negedge clk);
        check_eq("nack8", {bus.up_resp_nack, bus.up_resp_tag}, {1'b1, 4'd8});
        tick(1);
        bus.dn_req_rdy = 1'b1;
        tick(6);
        check_eq("drained", req_count, 0);

        // Pointer wrap: 20 requests against a toggling memory ready.
        d0 = delivered;
        n0 = nacks_seen;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    send(c_TB'(i) % 2 == 0, c_TB'(i));
                    tick(1);
                end
            end
            begin
                repeat (50) begin
                    @(posedge clk);
                    #1;
                    bus.dn_req_rdy = ~bus.dn_req_rdy;
                end
            end
        join
        bus.dn_req_rdy = 1'b1;
        tick(5);
        check_eq("wrap_delivered", delivered - d0, 20);
        check_eq("wrap_no_nacks", nacks_seen - n0, 0);

        // Reset mid-operation with three queued and one pending nack.
        bus.dn_req_rdy = 1'b0;
        for (int i = 0; i < 4; i++) send(1'b1, c_TB'(10 + i));
        bus.dn_resp_val = 1'b1;
        bus.dn_resp_tag = 4'd3;
        send(1'b0, 4'd14);
        bus.dn_req_rdy = 1'b1;
        tick(1);
        bus.dn_req_rdy = 1'b0;
        check_eq("mid_count_before", req_count, 3);
        #2;
        reset = 1'b0;
        #1;
        check_eq("mid_rst_dn", {bus.up_req_rdy, bus.dn_req_val, bus.dn_req_rw, bus.dn_req_addr,
                                bus.dn_req_data, bus.dn_req_tag, req_count}, '0);
        check_eq("mid_rst_up", {bus.up_resp_val, bus.up_resp_nack, bus.up_resp_data,
                                bus.up_resp_tag}, '0);
        tick(2);
        reset = 1'b1;
        bus.dn_resp_val = 1'b0;
        bus.dn_req_rdy = 1'b1;
        d0 = delivered;
        n0 = nacks_seen;
        @(negedge clk);
        check_eq("mid_rdy_after", bus.up_req_rdy, 1);
        tick(10);
        check_eq("mid_no_stale_req", delivered - d0, 0);
        check_eq("mid_no_stale_nack", nacks_seen - n0, 0);
        check_eq("mid_count_after", req_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_nack_queue.md
# mem_nack_queue

Request buffer and nack generator between the core's memory port and the off-chip memory controller. Core requests go into a small FIFO toward memory. A request arriving while that FIFO is full is still accepted, and its tag is returned to the core as a nack so the core's caches retry it. Memory responses pass straight through to the core; queued nacks use response cycles that memory leaves idle.

## Interface
- ADDR_BITS, 26, request address width
- DATA_BITS, 128, request/response data width
- TAG_BITS, 4, request/response tag width; MSB selects dcache (1) vs icache (0), opaque here
- REQ_DEPTH, 4, request FIFO entries, power of 2, ≥2
- NACK_DEPTH, 2, nack tag FIFO entries, power of 2, ≥1

Ports:
- clk  in  1  sole clock
- reset  in  1  asynchronous, active-low reset
- up_req_val / up_req_rdy  in / out  1 / 1  core request handshake
- up_req_rw  in  1  1 = write
- up_req_addr / up_req_data / up_req_tag  in  ADDR_BITS / DATA_BITS / TAG_BITS
- up_resp_val  out  1  response data valid
- up_resp_nack  out  1  tag on up_resp_tag was dropped; retry
- up_resp_data / up_resp_tag  out  DATA_BITS / TAG_BITS
- dn_req_val / dn_req_rdy  out / in  1 / 1  memory controller request handshake
- dn_req_rw / dn_req_addr / dn_req_data / dn_req_tag  out  1 / ADDR_BITS / DATA_BITS / TAG_BITS  FIFO head fields
- dn_resp_val / dn_resp_data / dn_resp_tag  in  1 / DATA_BITS / TAG_BITS  memory response; cannot be stalled
- req_count  out  clog2(REQ_DEPTH)+1  request FIFO occupancy

## Operation
- Request FIFO:
  - Circular buffer with rd_ptr/wr_ptr, each clog2(REQ_DEPTH) bits, wrapping modulo REQ_DEPTH.
  - req_count ranges 0..REQ_DEPTH.
- Nack FIFO: same structure, holds tags only; nack_count ranges 0..NACK_DEPTH.
- up_req_rdy = (nack_count != NACK_DEPTH). It depends only on registered state, with no combinational path from up_req_val.
- Accept = up_req_val & up_req_rdy. On accept:
  - If req_count < REQ_DEPTH: write {rw, addr, data, tag} at wr_ptr.
  - Else: push up_req_tag into the nack FIFO. Writes are nacked the same as reads.
  - Fullness is judged on the start-of-cycle count. A dequeue in the same cycle does not free a slot for the arriving request (no bypass).
- dn_req_val = (req_count != 0); dn_req_* show the head entry. Dequeue on dn_req_val & dn_req_rdy.
- Response mux, evaluated each cycle:
  - dn_resp_val=1: up_resp_val=1, up_resp_nack=0, data and tag passed through combinationally.
  - Otherwise, nack_count!=0: up_resp_val=0, up_resp_nack=1, up_resp_tag=nack head, up_resp_data=0; pop the nack FIFO.
  - Otherwise: up_resp_val=0, up_resp_nack=0, data=0, tag=0.
- Counts update as count + push − pop. A simultaneous push and pop leaves the count unchanged.
- Request order toward memory is strictly FIFO. Nack order is acceptance order. No reordering between nacks and memory responses is implied.

## Timing
- Reset low: all pointers and counts clear asynchronously. While reset is held:
  - up_req_rdy=0, dn_req_val=0, up_resp_val=0, up_resp_nack=0, req_count=0.
  - All data and tag outputs are 0.
- Reset mid-operation: queued requests and pending nacks are discarded; the core is responsible for re-issue.
- First cycle after reset deasserts: up_req_rdy=1.
- Enqueue to dn_req_val: accepted in cycle N into an empty FIFO gives dn_req_val=1 in N+1 (1-cycle latency, no bypass).
- Nack latency: request overflowed in cycle N gives up_resp_nack at the earliest in N+1, later if dn_resp_val is high.
- Response passthrough: 0 cycles.
- Sustained throughput: 1 request/cycle when dn_req_rdy=1.
- Nack starvation: continuous dn_resp_val holds nacks. After NACK_DEPTH overflows, up_req_rdy falls and stays low until a nack pops.

## Test plan
- Basic flow: reset, then 3 reads, tags 1, 2, 3, dn_req_rdy=1 -> dn_req_val in cycles 1-3 after the first accept, tags 1, 2, 3 in order; req_count peaks at 1.
- Overflow: dn_req_rdy=0, issue 6 requests, tags 0-5 -> tags 0-3 queued, req_count=4; tags 4, 5 nacked on consecutive cycles; up_req_rdy=0 after tag 5 until the first nack pops.
- Nack vs response: nack for tag 7 pending while dn_resp_val=1 for 3 cycles (tag 9) -> three responses with tag 9, then up_resp_nack=1 tag 7 in the 4th cycle.
- Full plus simultaneous dequeue: req_count=4, dn_req_rdy=1 and new request tag 8 in the same cycle -> tag 8 nacked, req_count=3.
- Pointer wrap: stream 20 requests with dn_req_rdy toggling 1/0 -> all 20 delivered in order, no nacks, data intact across wrap.
- Reset mid-operation: 3 queued plus 1 pending nack, assert reset -> req_count=0 and all outputs 0 immediately; after release, up_req_rdy=1 and no stale requests or nacks emerge.
